// File: rtl/fifo_frame_reader.sv
// Packs bytes from a first-word-fall-through FIFO into fixed-length frames for the
// transmit engine: length request/ack first, then a valid/ready byte stream padded on starvation.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a FIFO byte; latches the clamped frame length
// REQ    | tx_req high with tx_len, waiting for tx_ack
// SEND   | FIFO head passed straight through to the tx stream
// PAD    | FIFO starved too long; PAD_BYTE fills out the frame
module fifo_frame_reader #(
    parameter int unsigned MAX_LEN     = 1472,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    output logic        fifo_rd_en,
    input  logic        fifo_rd_vld,
    input  logic [7:0]  fifo_rd_data,
    input  logic [10:0] cfg_frame_len,
    output logic        tx_req,
    output logic [10:0] tx_len,
    input  logic        tx_ack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] pad_cnt
);

    localparam logic [10:0] MAX_LEN_W   = 11'(MAX_LEN);
    localparam logic [15:0] STARVE_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SEND = 2'd2,
        S_PAD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] len;
    logic [10:0] len_clamped;
    logic [10:0] byte_cnt;
    logic [15:0] starve_cnt;
    logic        pad_flag;
    logic        at_last;
    logic        xfer;
    logic        timeout;
    logic        frame_done;

    always_comb begin
        len_clamped = cfg_frame_len;
        if (cfg_frame_len == 11'd0) begin
            len_clamped = 11'd1;
        end else if (cfg_frame_len > MAX_LEN_W) begin
            len_clamped = MAX_LEN_W;
        end
    end

    assign at_last    = (byte_cnt == (len - 11'd1));
    assign xfer       = tx_valid && tx_ready;
    assign timeout    = (state == S_SEND) && !fifo_rd_vld && (starve_cnt == STARVE_LAST);
    assign frame_done = xfer && tx_last;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fifo_rd_vld) state_nxt = S_REQ;
            S_REQ:  if (tx_ack) state_nxt = S_SEND;
            S_SEND: begin
                if (frame_done) begin
                    state_nxt = S_IDLE;
                end else if (timeout) begin
                    state_nxt = S_PAD;
                end
            end
            S_PAD:  if (frame_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // SEND is a pure combinational pass-through so the FIFO head reaches tx_data with no added latency
    always_comb begin
        tx_req     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            S_REQ: tx_req = 1'b1;
            S_SEND: begin
                tx_valid   = fifo_rd_vld;
                tx_data    = fifo_rd_data;
                tx_last    = at_last && fifo_rd_vld;
                fifo_rd_en = tx_ready && fifo_rd_vld;
            end
            S_PAD: begin
                tx_valid = 1'b1;
                tx_data  = PAD_BYTE;
                tx_last  = at_last;
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign tx_len = len;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            len        <= 11'd0;
            byte_cnt   <= 11'd0;
            starve_cnt <= 16'd0;
            pad_flag   <= 1'b0;
            frame_cnt  <= 16'd0;
            pad_cnt    <= 16'd0;
        end else begin
            case (state)
                S_IDLE: if (fifo_rd_vld) len <= len_clamped;
                S_REQ: begin
                    if (tx_ack) begin
                        byte_cnt   <= 11'd0;
                        starve_cnt <= 16'd0;
                        pad_flag   <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        byte_cnt   <= byte_cnt + 11'd1;
                        starve_cnt <= 16'd0;
                    end else if (!fifo_rd_vld) begin
                        starve_cnt <= starve_cnt + 16'd1;
                    end
                    if (timeout) pad_flag <= 1'b1;
                end
                S_PAD: begin
                    pad_flag <= 1'b1;
                    if (tx_ready) byte_cnt <= byte_cnt + 11'd1;
                end
                default: ;
            endcase
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (pad_flag) pad_cnt <= pad_cnt + 16'd1;
            end
        end
    end

endmodule
